// File: rtl/eeg_pkg.sv
// Shared widths and alarm state encoding for the EEG window-energy block.
package eeg_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ENERGY_W = 32;
    localparam int SQ_W     = 31;   // exact width of a squared 16-bit sample
    localparam int CNT_W    = 12;   // window position counter (covers LOG2_WIN up to 12)
    localparam int CONF_W   = 4;    // confirm counter (covers CONFIRM up to 15)

    typedef enum logic [1:0] {
        QUIET    = 2'd0,
        PEND_ON  = 2'd1,
        ALARM    = 2'd2,
        PEND_OFF = 2'd3
    } alarm_state_t;

    // The alarm is asserted while latched on, including while an off-transition
    // is still being confirmed.
    function automatic logic alarm_level(input alarm_state_t s);
        return (s == ALARM) || (s == PEND_OFF);
    endfunction

endpackage

// File: rtl/eeg_alarm_fsm.sv
// Hysteretic seizure-activity alarm driven by per-window mean power.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   QUIET    | alarm off, no qualifying high-energy windows pending
//   PEND_ON  | alarm off, counting consecutive windows with E >= thr_hi
//   ALARM    | alarm on, no qualifying low-energy windows pending
//   PEND_OFF | alarm on, counting consecutive windows with E < thr_lo
//
// energy_valid/energy arrive one register stage early so that the registered
// alarm changes on the same edge that the top publishes energy_out.
module eeg_alarm_fsm
    import eeg_pkg::*;
#(
    parameter int CONFIRM = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                energy_valid,
    input  logic [ENERGY_W-1:0] energy,
    input  logic [ENERGY_W-1:0] thr_hi,
    input  logic [ENERGY_W-1:0] thr_lo,
    output logic                alarm
);

    localparam logic [CONF_W-1:0] CONF_C = CONF_W'(CONFIRM);

    alarm_state_t      state;
    logic [CONF_W-1:0] cnt;
    logic [CONF_W-1:0] cnt_inc;
    logic              above_hi;
    logic              below_lo;

    // Comparisons and the incremented confirm count used by every state.
    always_comb begin
        cnt_inc  = cnt + 1'b1;
        above_hi = (energy >= thr_hi);
        below_lo = (energy < thr_lo);
    end

    // State, confirm counter and registered alarm advance only on a new window energy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= QUIET;
            cnt   <= '0;
            alarm <= 1'b0;
        end else if (energy_valid) begin
            case (state)
                QUIET: begin
                    if (above_hi) begin
                        if (CONFIRM == 1) begin
                            state <= ALARM;
                            cnt   <= '0;
                            alarm <= alarm_level(ALARM);
                        end else begin
                            state <= PEND_ON;
                            cnt   <= CONF_W'(1);
                            alarm <= alarm_level(PEND_ON);
                        end
                    end
                end
                PEND_ON: begin
                    if (above_hi) begin
                        if (cnt_inc == CONF_C) begin
                            state <= ALARM;
                            cnt   <= '0;
                            alarm <= alarm_level(ALARM);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        state <= QUIET;
                        cnt   <= '0;
                        alarm <= alarm_level(QUIET);
                    end
                end
                ALARM: begin
                    if (below_lo) begin
                        if (CONFIRM == 1) begin
                            state <= QUIET;
                            cnt   <= '0;
                            alarm <= alarm_level(QUIET);
                        end else begin
                            state <= PEND_OFF;
                            cnt   <= CONF_W'(1);
                            alarm <= alarm_level(PEND_OFF);
                        end
                    end
                end
                PEND_OFF: begin
                    if (below_lo) begin
                        if (cnt_inc == CONF_C) begin
                            state <= QUIET;
                            cnt   <= '0;
                            alarm <= alarm_level(QUIET);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        state <= ALARM;
                        cnt   <= '0;
                        alarm <= alarm_level(ALARM);
                    end
                end
                default: begin
                    state <= QUIET;
                    cnt   <= '0;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/eeg_window_energy.sv
// Mean power over non-overlapping 2**LOG2_WIN-sample windows of the filtered
// EEG stream, with a hysteretic alarm on the resulting window energies.
// Two-stage pipeline: square, then accumulate/report.
module eeg_window_energy
    import eeg_pkg::*;
#(
    parameter int LOG2_WIN = 8,
    parameter int CONFIRM  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [ENERGY_W-1:0] thr_hi,
    input  logic [ENERGY_W-1:0] thr_lo,
    output logic [ENERGY_W-1:0] energy_out,
    output logic                energy_valid,
    output logic                alarm,
    output logic [CNT_W-1:0]    win_count
);

    localparam int               ACC_W    = SQ_W + LOG2_WIN;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2_WIN) - 1);

    logic [SAMPLE_W-1:0] mag;
    logic [SQ_W-1:0]     mag_ext;
    logic [SQ_W-1:0]     sq_next;
    logic                is_last;

    logic [SQ_W-1:0]     sq;
    logic                sq_last;
    logic                sq_valid;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [SQ_W-1:0]     energy_next;
    logic                report_now;

    // Square via magnitude: -32768 maps to 16'h8000 read as unsigned, giving 2**30 exactly.
    always_comb begin
        mag         = sample_in[SAMPLE_W-1] ? (~sample_in + 1'b1) : sample_in;
        mag_ext     = SQ_W'(mag);
        sq_next     = mag_ext * mag_ext;
        is_last     = (win_count == LAST_IDX);
        acc_sum     = acc + ACC_W'(sq);
        energy_next = acc_sum[ACC_W-1:LOG2_WIN];
        report_now  = sq_valid && sq_last;
    end

    // Stage 1: capture the square and its end-of-window flag; hold through gaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq        <= '0;
            sq_last   <= 1'b0;
            sq_valid  <= 1'b0;
            win_count <= '0;
        end else begin
            sq_valid <= sample_valid;
            if (sample_valid) begin
                sq        <= sq_next;
                sq_last   <= is_last;
                win_count <= is_last ? '0 : (win_count + 1'b1);
            end
        end
    end

    // Stage 2: accumulate each new square once; on the last one publish the mean and clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            energy_out   <= '0;
            energy_valid <= 1'b0;
        end else begin
            energy_valid <= 1'b0;
            if (sq_valid) begin
                if (sq_last) begin
                    acc          <= '0;
                    energy_out   <= ENERGY_W'(energy_next);
                    energy_valid <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    eeg_alarm_fsm #(
        .CONFIRM (CONFIRM)
    ) u_alarm_fsm (
        .clk          (clk),
        .reset        (reset),
        .energy_valid (report_now),
        .energy       (ENERGY_W'(energy_next)),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .alarm        (alarm)
    );

endmodule

// File: tb/tb_eeg_window_energy.sv
// Directed bench for eeg_window_energy with an abstract window/hysteresis model.
module tb_eeg_window_energy;

    localparam int L    = 2;
    localparam int CONF = 2;
    localparam int WIN  = 1 << L;

    logic        clk;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [31:0] thr_hi;
    logic [31:0] thr_lo;
    logic [31:0] energy_out;
    logic        energy_valid;
    logic        alarm;
    logic [11:0] win_count;

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 0;

    eeg_window_energy #(.LOG2_WIN(L), .CONFIRM(CONF)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .energy_out   (energy_out),
        .energy_valid (energy_valid),
        .alarm        (alarm),
        .win_count    (win_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: sums squares per window, schedules the report one edge after the
    // last capture, and tracks alarm as runs of qualifying windows.
    longint sum_m;
    int     cnt_m;
    int     edge_n;
    longint due_q[$];
    longint en_q[$];
    bit     exp_ev;
    longint exp_energy;
    bit     exp_alarm;
    int     run_m;
    int     exp_wc;

    always @(posedge clk) begin
        if (!reset) begin
            sum_m = 0; cnt_m = 0; edge_n = 0; run_m = 0;
            due_q.delete(); en_q.delete();
            exp_ev = 0; exp_energy = 0; exp_alarm = 0; exp_wc = 0;
        end else begin
            edge_n++;
            exp_ev = 0;
            if (due_q.size() > 0 && due_q[0] == edge_n) begin
                longint e;
                void'(due_q.pop_front());
                e = en_q.pop_front();
                exp_ev = 1;
                exp_energy = e;
                if (!exp_alarm) begin
                    run_m = (e >= longint'(thr_hi)) ? run_m + 1 : 0;
                    if (run_m == CONF) begin exp_alarm = 1; run_m = 0; end
                end else begin
                    run_m = (e < longint'(thr_lo)) ? run_m + 1 : 0;
                    if (run_m == CONF) begin exp_alarm = 0; run_m = 0; end
                end
            end
            if (sample_valid) begin
                longint s;
                s = longint'($signed(sample_in));
                sum_m += s * s;
                cnt_m++;
                if (cnt_m == WIN) begin
                    due_q.push_back(edge_n + 1);
                    en_q.push_back(sum_m >> L);
                    sum_m = 0;
                    cnt_m = 0;
                end
            end
            exp_wc = cnt_m;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking && reset) begin
            chk("energy_valid", energy_valid, exp_ev);
            if (exp_ev) chk("energy_out", energy_out, exp_energy);
            chk("alarm", alarm, exp_alarm);
            chk("win_count", win_count, exp_wc);
        end
    end

    task automatic push(input int v);
        sample_in    = 16'(v);
        sample_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One window, then check the report that lands two clocks after the last sample.
    task automatic send_window(input int a, input int b, input int c, input int d,
                               input longint e_exp, input int al_exp, input string name);
        push(a); push(b); push(c); push(d);
        idle(1);
        chk({name, "_pulse"}, energy_valid, 1);
        chk({name, "_energy"}, energy_out, e_exp);
        chk({name, "_alarm"}, alarm, al_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; sample_in = 0; sample_valid = 0;
        thr_hi = 32'hFFFF_FFFF; thr_lo = 0;
        repeat (3) @(negedge clk);
        chk("rst_energy_out", energy_out, 0);
        chk("rst_energy_valid", energy_valid, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_win_count", win_count, 0);
        reset = 1;
        checking = 1;
        idle(5);
        chk("idle_no_pulse", energy_valid, 0);

        // Basic window
        send_window(1, 2, 3, 4, 7, 0, "w1234");
        idle(2);

        // Full-scale negative, then back-to-back zero windows
        send_window(-32768, -32768, -32768, -32768, 1073741824, 0, "wmin");
        for (int i = 0; i < 8; i++) push(0);
        idle(1);
        chk("zeros_pulse", energy_valid, 1);
        chk("zeros_energy", energy_out, 0);
        idle(2);

        // Alarm on/off with hysteresis
        thr_hi = 100; thr_lo = 50;
        idle(1);
        send_window(20, 20, 0, 0, 200, 0, "a200a");
        send_window(20, 20, 0, 0, 200, 1, "a200b");
        send_window(10, 10, 10, 0, 75, 1, "a75");
        send_window(8, 8, -4, 4, 40, 1, "a40a");
        send_window(8, -8, 4, 4, 40, 0, "a40b");
        idle(2);

        // Interrupted confirmation
        send_window(20, -20, 0, 0, 200, 0, "b200a");
        send_window(16, 8, 0, 0, 80, 0, "b80");
        send_window(0, 0, 20, 20, 200, 0, "b200b");
        idle(2);

        // Gapped input then reset mid-window
        push(5); idle(2); push(5); idle(1);
        chk("gap_win_count", win_count, 2);
        reset = 0;
        @(negedge clk);
        chk("midrst_win_count", win_count, 0);
        chk("midrst_energy_valid", energy_valid, 0);
        chk("midrst_alarm", alarm, 0);
        @(negedge clk);
        reset = 1;
        idle(4);
        send_window(5, 5, 5, 5, 25, 0, "w5");
        idle(3);

        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
